mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 92 +++++++++
 rtl/mc_ctrl_if.sv | 54 +++++
 rtl/mc_decode.sv | 77 +++++++
 rtl/mc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared constants for the multicycle controller: opcode and
//               funct values, ALUOp / NPCOp / GPRSel / WDSel encodings,
//               FSM state encoding and the decoded-instruction types.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_lui   = 6'h0F;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  // R-type funct values (IR[5:0])
  localparam logic [5:0] c_fn_sll = 6'h00;
  localparam logic [5:0] c_fn_srl = 6'h02;
  localparam logic [5:0] c_fn_jr  = 6'h08;
  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_slt = 6'h2A;

  // ALUOp encoding
  localparam logic [3:0] c_alu_nop = 4'd0;
  localparam logic [3:0] c_alu_add = 4'd1;
  localparam logic [3:0] c_alu_sub = 4'd2;
  localparam logic [3:0] c_alu_and = 4'd3;
  localparam logic [3:0] c_alu_or  = 4'd4;
  localparam logic [3:0] c_alu_slt = 4'd5;
  localparam logic [3:0] c_alu_sll = 4'd6;
  localparam logic [3:0] c_alu_srl = 4'd7;
  localparam logic [3:0] c_alu_lui = 4'd8;

  // Next-PC select
  localparam logic [1:0] c_npc_pc4    = 2'b00;
  localparam logic [1:0] c_npc_branch = 2'b01;
  localparam logic [1:0] c_npc_jump   = 2'b10;
  localparam logic [1:0] c_npc_jr     = 2'b11;

  // Register-file destination select
  localparam logic [1:0] c_gpr_rd = 2'b00;
  localparam logic [1:0] c_gpr_rt = 2'b01;
  localparam logic [1:0] c_gpr_ra = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] c_wd_alu = 2'b00;
  localparam logic [1:0] c_wd_mem = 2'b01;
  localparam logic [1:0] c_wd_pc4 = 2'b10;

  // FSM state encoding
  localparam logic [2:0] c_st_fetch  = 3'd0;
  localparam logic [2:0] c_st_decode = 3'd1;
  localparam logic [2:0] c_st_exec   = 3'd2;
  localparam logic [2:0] c_st_mem    = 3'd3;
  localparam logic [2:0] c_st_wb     = 3'd4;
  localparam logic [2:0] c_st_trap   = 3'd5;

  // Instruction classes: decide the FSM path and strobe timing
  typedef enum logic [3:0] {
    c_cl_ralu = 4'd0,
    c_cl_ialu = 4'd1,
    c_cl_lw   = 4'd2,
    c_cl_sw   = 4'd3,
    c_cl_beq  = 4'd4,
    c_cl_bne  = 4'd5,
    c_cl_j    = 4'd6,
    c_cl_jr   = 4'd7,
    c_cl_jal  = 4'd8,
    c_cl_ill  = 4'd9
  } instr_class_t;

  // Static per-instruction selects produced by the decoder
  typedef struct packed {
    instr_class_t cls;
    logic [3:0]   alu_op;
    logic         alu_src;
    logic         ext_op;
    logic         alu_a;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_if
// Description : Control bundle between the multicycle controller and the
//               datapath / unified memory.
//   Inputs to controller : Op, Funct, Zero, mem_ready
//   Controller strobes   : MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite
//   Controller selects   : EXTOp, ALUSrc, ALU_A, ALUOp, NPCOp, GPRSel, WDSel
//   Debug / status       : state, illegal
//   Modports: master = controller side, slave = datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_ctrl_if;
  import mc_ctrl_pkg::*;

  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;

  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;

  logic       EXTOp;
  logic       ALUSrc;
  logic       ALU_A;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp;
  logic [1:0] GPRSel;
  logic [1:0] WDSel;

  logic [2:0] state;
  logic       illegal;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite,
    output EXTOp, ALUSrc, ALU_A, ALUOp, NPCOp, GPRSel, WDSel,
    output state, illegal
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite,
    input  EXTOp, ALUSrc, ALU_A, ALUOp, NPCOp, GPRSel, WDSel,
    input  state, illegal
  );

endinterface
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Pure combinational instruction decoder. Maps Op/Funct to an
//               instruction class plus the static ALU-side selects.
//   i_op    : opcode field
//   i_funct : R-type funct field
//   o_dec   : class, ALUOp, ALUSrc, EXTOp, ALU_A
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  dec_t w_dec;

  always_comb begin
    // Anything not matched below is trapped as illegal.
    w_dec.cls     = c_cl_ill;
    w_dec.alu_op  = c_alu_nop;
    w_dec.alu_src = 1'b0;
    w_dec.ext_op  = 1'b0;
    w_dec.alu_a   = 1'b0;

    case (i_op)
      c_op_rtype: begin
        case (i_funct)
          c_fn_add: begin w_dec.cls = c_cl_ralu; w_dec.alu_op = c_alu_add; end
          c_fn_sub: begin w_dec.cls = c_cl_ralu; w_dec.alu_op = c_alu_sub; end
          c_fn_and: begin w_dec.cls = c_cl_ralu; w_dec.alu_op = c_alu_and; end
          c_fn_or:  begin w_dec.cls = c_cl_ralu; w_dec.alu_op = c_alu_or;  end
          c_fn_slt: begin w_dec.cls = c_cl_ralu; w_dec.alu_op = c_alu_slt; end
          // Shifts take operand A from the shamt field.
          c_fn_sll: begin w_dec.cls = c_cl_ralu; w_dec.alu_op = c_alu_sll; w_dec.alu_a = 1'b1; end
          c_fn_srl: begin w_dec.cls = c_cl_ralu; w_dec.alu_op = c_alu_srl; w_dec.alu_a = 1'b1; end
          c_fn_jr:  begin w_dec.cls = c_cl_jr; end
          default:  begin w_dec.cls = c_cl_ill; end
        endcase
      end
      c_op_addi: begin
        w_dec.cls = c_cl_ialu; w_dec.alu_op = c_alu_add;
        w_dec.alu_src = 1'b1;  w_dec.ext_op = 1'b1;
      end
      // Logical immediates and lui are zero-extended.
      c_op_ori: begin
        w_dec.cls = c_cl_ialu; w_dec.alu_op = c_alu_or;
        w_dec.alu_src = 1'b1;
      end
      c_op_lui: begin
        w_dec.cls = c_cl_ialu; w_dec.alu_op = c_alu_lui;
        w_dec.alu_src = 1'b1;
      end
      c_op_lw: begin
        w_dec.cls = c_cl_lw;   w_dec.alu_op = c_alu_add;
        w_dec.alu_src = 1'b1;  w_dec.ext_op = 1'b1;
      end
      c_op_sw: begin
        w_dec.cls = c_cl_sw;   w_dec.alu_op = c_alu_add;
        w_dec.alu_src = 1'b1;  w_dec.ext_op = 1'b1;
      end
      // Branches compare rs and rt by subtraction.
      c_op_beq: begin w_dec.cls = c_cl_beq; w_dec.alu_op = c_alu_sub; end
      c_op_bne: begin w_dec.cls = c_cl_bne; w_dec.alu_op = c_alu_sub; end
      c_op_j:   begin w_dec.cls = c_cl_j;   end
      c_op_jal: begin w_dec.cls = c_cl_jal; end
      default:  begin w_dec.cls = c_cl_ill; end
    endcase
  end

  assign o_dec = w_dec;

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multicycle processor control FSM
//               (FETCH/DECODE/EXEC/MEM/WB/TRAP). Generates memory, IR, PC
//               and register-file strobes and the datapath selects.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : mc_ctrl_if.master - Op/Funct/Zero/mem_ready in, control out
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic       r_illegal;
  dec_t       w_dec;

  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_iord;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_reg_write;
  logic       w_ext_op;
  logic       w_alu_src;
  logic       w_alu_a;
  logic [3:0] w_alu_op;
  logic [1:0] w_npc_op;
  logic [1:0] w_gpr_sel;
  logic [1:0] w_wd_sel;
  logic       w_taken;

  mc_decode u_decode (
    .i_op    (bus.Op),
    .i_funct (bus.Funct),
    .o_dec   (w_dec)
  );

  // State register plus sticky trap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_st_fetch;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == c_st_decode && w_next_state == c_st_trap)
        r_illegal <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_fetch:  w_next_state = bus.mem_ready ? c_st_decode : c_st_fetch;
      c_st_decode: w_next_state = (w_dec.cls == c_cl_ill) ? c_st_trap : c_st_exec;
      c_st_exec: begin
        case (w_dec.cls)
          c_cl_lw, c_cl_sw:     w_next_state = c_st_mem;
          c_cl_ralu, c_cl_ialu: w_next_state = c_st_wb;
          default:              w_next_state = c_st_fetch;
        endcase
      end
      c_st_mem: begin
        if (bus.mem_ready)
          w_next_state = (w_dec.cls == c_cl_lw) ? c_st_wb : c_st_fetch;
      end
      c_st_wb:   w_next_state = c_st_fetch;
      c_st_trap: w_next_state = c_st_trap;
      default:   w_next_state = c_st_fetch;
    endcase
  end

  // Output decode. Everything idles at 0; rst masks all outputs so a
  // pending memory access is dropped in the reset cycle itself.
  always_comb begin
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_iord      = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_ext_op    = 1'b0;
    w_alu_src   = 1'b0;
    w_alu_a     = 1'b0;
    w_alu_op    = c_alu_nop;
    w_npc_op    = c_npc_pc4;
    w_gpr_sel   = c_gpr_rd;
    w_wd_sel    = c_wd_alu;
    w_taken     = 1'b0;

    if (!rst) begin
      case (r_state)
        c_st_fetch: begin
          w_mem_read = 1'b1;
          w_ir_write = bus.mem_ready;
        end
        c_st_exec: begin
          case (w_dec.cls)
            c_cl_ralu, c_cl_ialu, c_cl_lw, c_cl_sw: begin
              w_alu_op  = w_dec.alu_op;
              w_alu_src = w_dec.alu_src;
              w_ext_op  = w_dec.ext_op;
              w_alu_a   = w_dec.alu_a;
            end
            c_cl_beq, c_cl_bne: begin
              w_alu_op   = w_dec.alu_op;
              w_alu_src  = w_dec.alu_src;
              w_taken    = (w_dec.cls == c_cl_beq) ? bus.Zero : !bus.Zero;
              w_pc_write = w_taken;
              w_npc_op   = w_taken ? c_npc_branch : c_npc_pc4;
            end
            c_cl_j: begin
              w_pc_write = 1'b1;
              w_npc_op   = c_npc_jump;
            end
            c_cl_jr: begin
              w_pc_write = 1'b1;
              w_npc_op   = c_npc_jr;
            end
            c_cl_jal: begin
              w_pc_write  = 1'b1;
              w_npc_op    = c_npc_jump;
              w_reg_write = 1'b1;
              w_gpr_sel   = c_gpr_ra;
              w_wd_sel    = c_wd_pc4;
            end
            default: ;
          endcase
        end
        c_st_mem: begin
          w_iord      = 1'b1;
          w_mem_read  = (w_dec.cls == c_cl_lw);
          w_mem_write = (w_dec.cls == c_cl_sw);
          // sw ends here, so its PC update rides on the completing access.
          w_pc_write  = (w_dec.cls == c_cl_sw) && bus.mem_ready;
        end
        c_st_wb: begin
          w_reg_write = 1'b1;
          w_pc_write  = 1'b1;
          w_gpr_sel   = (w_dec.cls == c_cl_ralu) ? c_gpr_rd : c_gpr_rt;
          w_wd_sel    = (w_dec.cls == c_cl_lw)   ? c_wd_mem : c_wd_alu;
        end
        default: ;
      endcase
    end
  end

  assign bus.MemRead  = w_mem_read;
  assign bus.MemWrite = w_mem_write;
  assign bus.IorD     = w_iord;
  assign bus.IRWrite  = w_ir_write;
  assign bus.PCWrite  = w_pc_write;
  assign bus.RegWrite = w_reg_write;
  assign bus.EXTOp    = w_ext_op;
  assign bus.ALUSrc   = w_alu_src;
  assign bus.ALU_A    = w_alu_a;
  assign bus.ALUOp    = w_alu_op;
  assign bus.NPCOp    = w_npc_op;
  assign bus.GPRSel   = w_gpr_sel;
  assign bus.WDSel    = w_wd_sel;
  assign bus.state    = r_state;
  assign bus.illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_ctrl
// Description : Self-checking bench for mc_ctrl. The stimulus process pushes
//               a hand-computed per-cycle output snapshot into a queue; a
//               monitor on the falling edge pops and compares it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

  // strb bit order: {MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite}
  // ea   bit order: {EXTOp, ALUSrc, ALU_A}
  typedef struct packed {
    logic [2:0] st;
    logic [5:0] strb;
    logic [2:0] ea;
    logic [3:0] alu;
    logic [1:0] npc;
    logic [1:0] gpr;
    logic [1:0] wd;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t  exp_q[$];
  string nm_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  exp_t  m_exp;
  exp_t  m_act;
  string m_nm;

  function automatic exp_t ex(input logic [2:0] st, input logic [5:0] strb,
                              input logic [2:0] ea, input logic [3:0] alu,
                              input logic [1:0] npc, input logic [1:0] gpr,
                              input logic [1:0] wd, input logic ill);
    exp_t e;
    e.st = st; e.strb = strb; e.ea = ea; e.alu = alu;
    e.npc = npc; e.gpr = gpr; e.wd = wd; e.ill = ill;
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("st=%0d strb=%b ea=%b alu=%0d npc=%b gpr=%b wd=%b ill=%b",
                     e.st, e.strb, e.ea, e.alu, e.npc, e.gpr, e.wd, e.ill);
  endfunction

  // Monitor: compares one expected snapshot per cycle, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_exp = exp_q.pop_front();
      m_nm  = nm_q.pop_front();
      m_act.st   = bus.state;
      m_act.strb = {bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite, bus.RegWrite};
      m_act.ea   = {bus.EXTOp, bus.ALUSrc, bus.ALU_A};
      m_act.alu  = bus.ALUOp;
      m_act.npc  = bus.NPCOp;
      m_act.gpr  = bus.GPRSel;
      m_act.wd   = bus.WDSel;
      m_act.ill  = bus.illegal;
      n_checks++;
      if (m_act !== m_exp) begin
        n_err++;
        $display("FAIL %s: got %s, expected %s", m_nm, fmt(m_act), fmt(m_exp));
      end
    end
  end

  // Queue one cycle's expectation, then advance to just past the next edge.
  task automatic cyc(input exp_t e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Zero-wait ALU instruction: FETCH, DECODE, EXEC, WB.
  task automatic alu4(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] ea,
                      input logic [3:0] alu, input logic [1:0] gpr, input string nm);
    bus.Op = op; bus.Funct = fn; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    cyc(ex(3'd0, 6'b100100, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), {nm, "_fetch"});
    cyc(ex(3'd1, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), {nm, "_decode"});
    cyc(ex(3'd2, 6'b000000, ea,     alu,  2'b00, 2'b00, 2'b00, 1'b0), {nm, "_exec"});
    cyc(ex(3'd4, 6'b000011, 3'b000, 4'd0, 2'b00, gpr,   2'b00, 1'b0), {nm, "_wb"});
  endtask

  // Branch / jump: FETCH, DECODE, EXEC (final state).
  task automatic ctl3(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                      input logic [5:0] strb, input logic [3:0] alu, input logic [1:0] npc,
                      input logic [1:0] gpr, input logic [1:0] wd, input string nm);
    bus.Op = op; bus.Funct = fn; bus.Zero = zero; bus.mem_ready = 1'b1;
    cyc(ex(3'd0, 6'b100100, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), {nm, "_fetch"});
    cyc(ex(3'd1, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), {nm, "_decode"});
    cyc(ex(3'd2, strb,      3'b000, alu,  npc,   gpr,   wd,    1'b0), {nm, "_exec"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.Op = 6'h00; bus.Funct = 6'h20; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // rst still high: FETCH, everything silent.
    cyc(ex(3'd0, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "reset");
    rst = 1'b0;

    alu4(6'h00, 6'h20, 3'b000, 4'd1, 2'b00, "add");
    alu4(6'h00, 6'h22, 3'b000, 4'd2, 2'b00, "sub");
    alu4(6'h00, 6'h24, 3'b000, 4'd3, 2'b00, "and");
    alu4(6'h00, 6'h25, 3'b000, 4'd4, 2'b00, "or");
    alu4(6'h00, 6'h2A, 3'b000, 4'd5, 2'b00, "slt");
    alu4(6'h00, 6'h00, 3'b001, 4'd6, 2'b00, "sll");
    alu4(6'h00, 6'h02, 3'b001, 4'd7, 2'b00, "srl");
    alu4(6'h08, 6'h00, 3'b110, 4'd1, 2'b01, "addi");
    alu4(6'h0D, 6'h00, 3'b010, 4'd4, 2'b01, "ori");
    alu4(6'h0F, 6'h00, 3'b010, 4'd8, 2'b01, "lui");

    // lw: 2 wait cycles in FETCH, 3 in MEM -> 10 cycles.
    bus.Op = 6'h23; bus.Funct = 6'h00; bus.mem_ready = 1'b0;
    cyc(ex(3'd0, 6'b100000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "lw_fetch_w1");
    cyc(ex(3'd0, 6'b100000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "lw_fetch_w2");
    bus.mem_ready = 1'b1;
    cyc(ex(3'd0, 6'b100100, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "lw_fetch_done");
    cyc(ex(3'd1, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "lw_decode");
    cyc(ex(3'd2, 6'b000000, 3'b110, 4'd1, 2'b00, 2'b00, 2'b00, 1'b0), "lw_exec");
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(ex(3'd3, 6'b101000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "lw_mem_wait");
    bus.mem_ready = 1'b1;
    cyc(ex(3'd3, 6'b101000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "lw_mem_done");
    cyc(ex(3'd4, 6'b000011, 3'b000, 4'd0, 2'b00, 2'b01, 2'b01, 1'b0), "lw_wb");

    // sw zero-wait: 4 cycles, PC written with the completing store.
    bus.Op = 6'h2B;
    cyc(ex(3'd0, 6'b100100, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "sw_fetch");
    cyc(ex(3'd1, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "sw_decode");
    cyc(ex(3'd2, 6'b000000, 3'b110, 4'd1, 2'b00, 2'b00, 2'b00, 1'b0), "sw_exec");
    cyc(ex(3'd3, 6'b011010, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "sw_mem");

    ctl3(6'h04, 6'h00, 1'b1, 6'b000010, 4'd2, 2'b01, 2'b00, 2'b00, "beq_taken");
    ctl3(6'h04, 6'h00, 1'b0, 6'b000000, 4'd2, 2'b00, 2'b00, 2'b00, "beq_not_taken");
    ctl3(6'h05, 6'h00, 1'b0, 6'b000010, 4'd2, 2'b01, 2'b00, 2'b00, "bne_taken");
    ctl3(6'h05, 6'h00, 1'b1, 6'b000000, 4'd2, 2'b00, 2'b00, 2'b00, "bne_not_taken");
    ctl3(6'h02, 6'h00, 1'b0, 6'b000010, 4'd0, 2'b10, 2'b00, 2'b00, "j");
    ctl3(6'h00, 6'h08, 1'b0, 6'b000010, 4'd0, 2'b11, 2'b00, 2'b00, "jr");
    ctl3(6'h03, 6'h00, 1'b0, 6'b000011, 4'd0, 2'b10, 2'b10, 2'b10, "jal");

    // sw stalled in MEM, then reset: store dropped, no PC update.
    bus.Op = 6'h2B; bus.Funct = 6'h00;
    cyc(ex(3'd0, 6'b100100, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "swr_fetch");
    cyc(ex(3'd1, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "swr_decode");
    cyc(ex(3'd2, 6'b000000, 3'b110, 4'd1, 2'b00, 2'b00, 2'b00, 1'b0), "swr_exec");
    bus.mem_ready = 1'b0;
    cyc(ex(3'd3, 6'b011000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "swr_mem_wait");
    rst = 1'b1;
    cyc(ex(3'd3, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "swr_rst_cycle");
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    // The next instruction's first cycle confirms the return to FETCH.

    // Unsupported R-type funct traps.
    bus.Op = 6'h00; bus.Funct = 6'h01;
    cyc(ex(3'd0, 6'b100100, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "badfn_fetch_after_swr");
    cyc(ex(3'd1, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "badfn_decode");
    cyc(ex(3'd5, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b1), "badfn_trap1");
    cyc(ex(3'd5, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b1), "badfn_trap2");
    rst = 1'b1;
    cyc(ex(3'd5, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b1), "badfn_rst_cycle");
    cyc(ex(3'd0, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "badfn_rst_fetch");
    rst = 1'b0;

    // Op 0x3F traps; stays silent for 20 cycles even with mem_ready toggling.
    bus.Op = 6'h3F; bus.Funct = 6'h00;
    cyc(ex(3'd0, 6'b100100, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "trap_fetch");
    cyc(ex(3'd1, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "trap_decode");
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      bus.Zero      = i[1];
      cyc(ex(3'd5, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b1), "trap_hold");
    end
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    cyc(ex(3'd5, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b1), "trap_rst_cycle");
    cyc(ex(3'd0, 6'b000000, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "trap_rst_fetch");
    rst = 1'b0;
    bus.Op = 6'h00; bus.Funct = 6'h20;
    cyc(ex(3'd0, 6'b100100, 3'b000, 4'd0, 2'b00, 2'b00, 2'b00, 1'b0), "post_trap_fetch");

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
